// File: rtl/shift_load_sched_pkg.sv
// ----------------------------------------------------------------------------
// shift_load_sched_pkg
// Shared definitions for the shift_load_sched scheduler: FSM state encoding,
// default sizing and requester index constants.
// ----------------------------------------------------------------------------
package shift_load_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    // Requester indices (also the encoding of done_id)
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage : shift_load_sched_pkg

// File: rtl/shift_load_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from the
// request vector and the last-grant pointer; on a tie the requester that is
// NOT the pointer wins. The pointer takes the granted index when i_update is
// high (i.e. when the grant turned into a handshake).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset (pointer -> 1)
//   i_req     in   [1:0] request vector
//   i_update  in   grant was accepted this cycle; move the pointer
//   o_grant   out  [1:0] one-hot grant (zero when no request)
// ----------------------------------------------------------------------------
module rr_arb2
    import shift_load_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant selection from requests and last-grant pointer
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_ptr == REQ_ID1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Last-grant pointer; starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= REQ_ID1;
        end else if (i_update) begin
            r_ptr <= o_grant[1];
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule : rr_arb2

// File: rtl/shift_load_sched.sv
// ----------------------------------------------------------------------------
// shift_load_sched
// Round-robin scheduler sharing one serial-in, shift-left register between
// two parallel-word requesters. A word accepted by valid/ready handshake is
// shifted out MSB-first over WIDTH cycles, then the register's parallel
// value is reported with a one-cycle done pulse.
//
// Configuration macro: SHIFT_LOAD_SCHED_CHECK_EN
//   defined   -> mismatch flags a captured value differing from the sent word
//   undefined -> mismatch tied low, no word copy kept
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset, aborts any transfer
//   req_valid    in   [1:0] per-requester word available
//   req_data0/1  in   [WIDTH-1:0] words from requester 0 / 1
//   req_ready    out  [1:0] one-hot accept (IDLE only)
//   sr_d         out  serial bit to the shift register
//   sr_shift_en  out  shift strobe to the shift register
//   sr_q         in   [WIDTH-1:0] parallel readback of the shift register
//   busy         out  high in SHIFT and CAPTURE
//   done         out  one-cycle completion pulse
//   done_id      out  requester index of the completed transfer
//   result       out  [WIDTH-1:0] captured register value, held to next done
//   mismatch     out  capture check result (see macro above)
// ----------------------------------------------------------------------------
module shift_load_sched
    import shift_load_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             sr_d,
    output logic             sr_shift_en,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             mismatch
);

    state_t           r_state;
    logic [WIDTH-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic             r_sr_d;
    logic             r_shift_en;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;
    logic [WIDTH-1:0] r_result;

    logic [1:0]       w_arb_req;
    logic [1:0]       w_grant;
    logic             w_hs;
    logic             w_last_shift;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_sr_final;

    // Requests only reach the arbiter in IDLE, so ready is zero elsewhere
    assign w_arb_req = (r_state == ST_IDLE) ? req_valid : 2'b00;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_arb_req),
        .i_update (w_hs),
        .o_grant  (w_grant)
    );

    assign req_ready    = w_grant;
    assign w_hs         = |(req_valid & w_grant);
    assign w_word       = w_grant[1] ? req_data1 : req_data0;
    assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    // The last bit enters the register on the same edge that enters CAPTURE,
    // so the value the register holds during CAPTURE is sr_q shifted once
    // with the final serial bit. Capturing it here makes result valid
    // together with done.
    assign w_sr_final = (sr_q << 1) | {{(WIDTH-1){1'b0}}, r_sr_d};

    // Scheduler FSM with next-state-decoded registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_buf      <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_id       <= REQ_ID0;
            r_sr_d     <= 1'b0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_hs) begin
                        // First bit goes out immediately; buffer keeps the rest
                        r_state    <= ST_SHIFT;
                        r_buf      <= {w_word[WIDTH-2:0], 1'b0};
                        r_sr_d     <= w_word[WIDTH-1];
                        r_shift_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_id       <= w_grant[1];
                        r_cnt      <= {CNT_W{1'b0}};
                    end else begin
                        r_state    <= ST_IDLE;
                        r_sr_d     <= 1'b0;
                        r_shift_en <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_shift) begin
                        r_state    <= ST_CAPTURE;
                        r_sr_d     <= 1'b0;
                        r_shift_en <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_id  <= r_id;
                        r_result   <= w_sr_final;
                    end else begin
                        r_state    <= ST_SHIFT;
                        r_sr_d     <= r_buf[WIDTH-1];
                        r_buf      <= {r_buf[WIDTH-2:0], 1'b0};
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_sr_d     <= 1'b0;
                    r_shift_en <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign sr_d        = r_sr_d;
    assign sr_shift_en = r_shift_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_id     = r_done_id;
    assign result      = r_result;

`ifdef SHIFT_LOAD_SCHED_CHECK_EN
    logic [WIDTH-1:0] r_word;
    logic             r_mismatch;

    // Copy of the accepted word and capture-time comparison against it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word     <= {WIDTH{1'b0}};
            r_mismatch <= 1'b0;
        end else begin
            if (w_hs) begin
                r_word <= w_word;
            end else begin
                r_word <= r_word;
            end
            if (w_last_shift) begin
                r_mismatch <= (w_sr_final != r_word);
            end else begin
                r_mismatch <= r_mismatch;
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule : shift_load_sched

// File: tb/tb_shift_load_sched.sv
module tb_shift_load_sched;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic [1:0]   req_ready;
    logic         sr_d;
    logic         sr_shift_en;
    logic [W-1:0] sr_q;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] result;
    logic         mismatch;

    // Behavioural serial-in shift-left register, optionally stubbed to zero
    logic [W-1:0] sr_model = '0;
    logic         stub = 1'b0;
    always @(posedge clk) if (sr_shift_en) sr_model <= {sr_model[W-2:0], sr_d};
    assign sr_q = stub ? '0 : sr_model;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_load_sched #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .sr_d(sr_d), .sr_shift_en(sr_shift_en), .sr_q(sr_q), .busy(busy),
        .done(done), .done_id(done_id), .result(result), .mismatch(mismatch)
    );

    typedef struct {
        logic [1:0]   v;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [1:0]   rdy;
        logic         id;
        logic [W-1:0] word;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " sr_shift_en"}, sr_shift_en, 0);
        chk({tag, " sr_d"}, sr_d, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    // One complete transfer: handshake cycle, W shift cycles, capture cycle.
    // Returns #1 after the edge that leaves CAPTURE (next handshake cycle).
    task automatic run_xfer(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [1:0] exp_rdy, input logic exp_id, input logic [W-1:0] exp_word,
                            input bit chk_res, input logic exp_mm, input bit b2b);
        req_valid = v; req_data0 = d0; req_data1 = d1;
        @(negedge clk);
        chk("handshake req_ready", req_ready, exp_rdy);
        chk("handshake busy", busy, 0);
        @(posedge clk); #1;
        // Requester inputs change during the transfer and must be ignored
        req_data0 = ~d0; req_data1 = ~d1;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("shift sr_shift_en", sr_shift_en, 1);
            chk("shift sr_d", sr_d, exp_word[W-1-k]);
            chk("shift req_ready", req_ready, 0);
            chk("shift done", done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("capture done", done, 1);
        chk("capture done_id", done_id, exp_id);
        if (chk_res) chk("capture result", result, exp_word);
        chk("capture mismatch", mismatch, exp_mm);
        chk("capture sr_shift_en", sr_shift_en, 0);
        chk("capture busy", busy, 1);
        chk("capture req_ready", req_ready, 0);
        if (b2b) chk("done spacing", cyc - last_done_cyc, W + 2);
        last_done_cyc = cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{2'b11, 4'h3, 4'hC, 2'b01, 1'b0, 4'h3};
        vecs[1]  = '{2'b11, 4'h3, 4'hC, 2'b10, 1'b1, 4'hC};
        vecs[2]  = '{2'b11, 4'hA, 4'h5, 2'b01, 1'b0, 4'hA};
        vecs[3]  = '{2'b11, 4'hA, 4'h5, 2'b10, 1'b1, 4'h5};
        vecs[4]  = '{2'b11, 4'hA, 4'h5, 2'b01, 1'b0, 4'hA};
        vecs[5]  = '{2'b11, 4'hA, 4'h5, 2'b10, 1'b1, 4'h5};
        vecs[6]  = '{2'b01, 4'hB, 4'h0, 2'b01, 1'b0, 4'hB};
        vecs[7]  = '{2'b01, 4'h9, 4'h0, 2'b01, 1'b0, 4'h9};
        vecs[8]  = '{2'b10, 4'h0, 4'hE, 2'b10, 1'b1, 4'hE};
        vecs[9]  = '{2'b10, 4'h0, 4'h1, 2'b10, 1'b1, 4'h1};
        vecs[10] = '{2'b11, 4'h4, 4'h2, 2'b01, 1'b0, 4'h4};

        reset = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset done_id", done_id, 0);
        chk("reset result", result, 0);
        chk("reset mismatch", mismatch, 0);
        chk("reset req_ready", req_ready, 0);

        // Withdrawn request: ready follows valid, but no transfer starts
        #1 req_valid = 2'b10;
        #1 chk("withdraw req_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle_outputs("withdraw");

        // Table-driven back-to-back transfers
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            run_xfer(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].id,
                     vecs[i].word, 1'b1, 1'b0, i > 0);
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk_idle_outputs("post-table");
        chk("held result", result, 4'h4);

        // Reset during the second SHIFT cycle aborts the transfer
        @(posedge clk); #1;
        req_valid = 2'b01; req_data0 = 4'hD;
        @(negedge clk);
        chk("abort handshake", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("abort");
        chk("abort done_id", done_id, 0);
        chk("abort result", result, 0);
        chk("abort mismatch", mismatch, 0);
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk("abort no done", done, 0);
        end
        @(posedge clk); #1;
        // Pointer is back at 1, so the tie goes to requester 0
        run_xfer(2'b11, 4'h2, 4'h8, 2'b01, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
        req_valid = 2'b00;

`ifdef SHIFT_LOAD_SCHED_CHECK_EN
        @(posedge clk); #1;
        stub = 1'b1;
        run_xfer(2'b01, 4'hF, 4'h0, 2'b01, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        req_valid = 2'b00; stub = 1'b0;
        @(negedge clk);
        chk("mismatch held", mismatch, 1);
        @(posedge clk); #1;
        run_xfer(2'b10, 4'h0, 4'h6, 2'b10, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
        req_valid = 2'b00;
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
